// File: rtl/q8_8_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// q8_8_addsub_arbiter
//
// Round-robin arbiter/sequencer sharing one Q8.8 add/sub unit between
// NUM_REQ requesters. An accepted operation is latched (IDLE -> EXEC),
// evaluated on the shared unit and registered into the response
// (EXEC -> RESP), then held until the consumer takes it (RESP -> IDLE).
// One operation every 3 cycles when the response side never stalls.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   req_valid     per-requester operation valid
//   req_ready     per-requester accept strobe (only ever high in IDLE)
//   req_operand1  packed operand1, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   req_operand2  packed operand2, same packing
//   req_add_sub   per-requester select: 0 = add, 1 = subtract (magnitude)
//   rsp_valid     response valid
//   rsp_ready     response consumer ready
//   rsp_id        index of the requester owning the response
//   rsp_result    BUS_WIDTH+1 bit result
//   busy          high whenever the sequencer is not in IDLE
//   op_count      completed-response counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module q8_8_addsub_arbiter #(
    parameter int BUS_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_operand1,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_operand2,
    input  logic [NUM_REQ-1:0]             req_add_sub,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [BUS_WIDTH:0]             rsp_result,
    output logic                           busy,
    output logic [15:0]                    op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Shared Q8_8_AddSub behaviour: add keeps the carry in the MSB,
    // subtract returns the magnitude of the difference (MSB always 0).
    function automatic logic [BUS_WIDTH:0] q8_8_addsub(
        input logic [BUS_WIDTH-1:0] a,
        input logic [BUS_WIDTH-1:0] b,
        input logic                 sub
    );
        logic [BUS_WIDTH:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b};
        end else if (a > b) begin
            r = {1'b0, a - b};
        end else begin
            r = {1'b0, b - a};
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    grant_q, grant_d;
    logic [BUS_WIDTH-1:0]   op1_q, op1_d;
    logic [BUS_WIDTH-1:0]   op2_q, op2_d;
    logic                   sub_q, sub_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
    logic [BUS_WIDTH:0]     rsp_result_q, rsp_result_d;
    logic [15:0]            op_count_q, op_count_d;

    logic [2*NUM_REQ-1:0]   valid_dbl;
    logic [NUM_REQ-1:0]     valid_rot;
    logic                   any_valid;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [BUS_WIDTH-1:0]   sel_op1;
    logic [BUS_WIDTH-1:0]   sel_op2;
    logic                   sel_sub;

    // Round-robin search: rotate the valid vector so rr_ptr lands at bit 0,
    // then take the lowest set bit. Scanning downward lets the lowest
    // position overwrite any higher match.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
        valid_rot = valid_dbl[NUM_REQ-1:0];
        any_valid = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                any_valid = 1'b1;
                grant_idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Operand mux for the granted requester; ready strobe only in IDLE.
    always_comb begin
        sel_op1   = '0;
        sel_op2   = '0;
        sel_sub   = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_op1 = req_operand1[i*BUS_WIDTH +: BUS_WIDTH];
                sel_op2 = req_operand2[i*BUS_WIDTH +: BUS_WIDTH];
                sel_sub = req_add_sub[i];
                req_ready[i] = (state_q == IDLE) && any_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        sub_d        = sub_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = grant_idx;
                    op1_d   = sel_op1;
                    op2_d   = sel_op2;
                    sub_d   = sel_sub;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = q8_8_addsub(op1_q, op2_q, sub_q);
                rsp_id_d     = grant_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                // Pointer moves only on completion so a stalled response
                // cannot let other requesters skip ahead twice.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    rr_ptr_d    = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            sub_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            sub_q        <= sub_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_q8_8_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_q8_8_addsub_arbiter
//
// Self-checking bench for q8_8_addsub_arbiter (NUM_REQ=4, BUS_WIDTH=16).
// Expected responses are pushed to a scoreboard queue when a grant is seen
// and popped when the response appears. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1-2 units after the rising edge.
// ---------------------------------------------------------------------------
module tb_q8_8_addsub_arbiter;

    localparam int BW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*BW-1:0]  op1;
    logic [NR*BW-1:0]  op2;
    logic [NR-1:0]     add_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [BW:0]       rsp_result;
    logic              busy;
    logic [15:0]       op_count;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [BW:0]   res;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    q8_8_addsub_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_operand1 (op1),
        .req_operand2 (op2),
        .req_add_sub  (add_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [BW:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic s);
        if (!s) return 17'(a) + 17'(b);
        if (a > b) return 17'(a) - 17'(b);
        return 17'(b) - 17'(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid for one requester and hold until its req_ready is seen.
    task automatic issue(input int idx, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic s, output int waited);
        bit got;
        got    = 1'b0;
        waited = -1;
        op1[idx*BW +: BW] = a;
        op2[idx*BW +: BW] = b;
        add_sub[idx]      = s;
        req_valid[idx]    = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            #1;
            if (req_ready[idx] === 1'b1) begin
                got    = 1'b1;
                waited = n;
                exp_q.push_back('{id: IW'(idx), res: model(a, b, s)});
            end
            @(posedge clk);
            #1;
        end
        req_valid[idx] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL issue_grant req=%0d: req_ready never seen, required within 16 cycles", idx);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        op1       = '0;
        op2       = '0;
        add_sub   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        checks += 6;
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        if (rsp_id !== 2'd0)     begin errors++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        if (rsp_result !== '0)   begin errors++; $display("FAIL reset_rsp_result got=%h want=0", rsp_result); end
        if (op_count !== 16'd0)  begin errors++; $display("FAIL reset_op_count got=%h want=0", op_count); end
        if (req_ready !== 4'd0)  begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        int   w;
        exp_t e;
        rsp_ready = 1'b1;  // ready before valid must not complete anything
        issue(0, 16'h0180, 16'h0040, 1'b0, w);
        checks += 4;
        if (w !== 0)            begin errors++; $display("FAIL add_grant_delay got=%0d want=0", w); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_rsp_valid got=%b want=0", rsp_valid); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL add_exec_busy got=%b want=1", busy); end
        if (op_count !== 16'd0) begin errors++; $display("FAIL add_early_ready got=%h want=0", op_count); end
        req_valid[0] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'd0) begin errors++; $display("FAIL add_ready_in_exec got=%b want=0000", req_ready); end
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency rsp_valid got=%b want=1", rsp_valid);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if (rsp_id !== e.id)         begin errors++; $display("FAIL add_id got=%0d want=%0d", rsp_id, e.id); end
            if (rsp_result !== e.res)    begin errors++; $display("FAIL add_result got=%h want=%h", rsp_result, e.res); end
            if (rsp_result !== 17'h001C0) begin errors++; $display("FAIL add_const got=%h want=001c0", rsp_result); end
        end
        tick();
        checks += 3;
        if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count got=%h want=1", op_count); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop got=%b want=0", rsp_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL add_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_subtract();
        logic [BW-1:0] ta[4] = '{16'h0100, 16'h1234, 16'hFFFF, 16'h0500};
        logic [BW-1:0] tb[4] = '{16'h0300, 16'h1234, 16'h0001, 16'h0180};
        logic          ts[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [BW:0]   tr[4] = '{17'h00200, 17'h00000, 17'h10000, 17'h00380};
        int   w;
        bit   ok;
        exp_t e;
        rsp_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            issue(2, ta[v], tb[v], ts[v], w);
            wait_rsp(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sub_rsp_timeout vec=%0d no rsp_valid within 16 cycles", v);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 2;
                if (rsp_id !== e.id || rsp_result !== e.res) begin
                    errors++;
                    $display("FAIL sub_model vec=%0d got id=%0d res=%h want id=%0d res=%h",
                             v, rsp_id, rsp_result, e.id, e.res);
                end
                if (rsp_result !== tr[v]) begin
                    errors++;
                    $display("FAIL sub_const vec=%0d got=%h want=%h", v, rsp_result, tr[v]);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int   gnt_id[$];
        int   gnt_cyc[$];
        int   last;
        exp_t e;
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            op1[i*BW +: BW] = 16'($urandom);
            op2[i*BW +: BW] = 16'($urandom);
            add_sub[i]      = 1'($urandom);
        end
        req_valid = '1;
        last      = -1;
        for (int c = 0; c < 24; c++) begin
            if (last >= 0) begin
                op1[last*BW +: BW] = 16'($urandom);
                op2[last*BW +: BW] = 16'($urandom);
                add_sub[last]      = 1'($urandom);
                last = -1;
            end
            #1;
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_unexpected_rsp cyc=%0d id=%0d", c, rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_result !== e.res) begin
                        errors++;
                        $display("FAIL rr_rsp cyc=%0d got id=%0d res=%h want id=%0d res=%h",
                                 c, rsp_id, rsp_result, e.id, e.res);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] === 1'b1 && last < 0) begin
                    last = i;
                    gnt_id.push_back(i);
                    gnt_cyc.push_back(c);
                    exp_q.push_back('{id: IW'(i),
                                      res: model(op1[i*BW +: BW], op2[i*BW +: BW], add_sub[i])});
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        checks += 3;
        if (gnt_id.size() != 8) begin
            errors++;
            $display("FAIL rr_grant_count got=%0d want=8", gnt_id.size());
        end
        if (op_count !== 16'd8) begin errors++; $display("FAIL rr_op_count got=%h want=8", op_count); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL rr_pending got=%0d want=0", exp_q.size()); end
        for (int k = 0; k < gnt_id.size(); k++) begin
            checks++;
            if (gnt_id[k] != k % NR || gnt_cyc[k] != 3 * k) begin
                errors++;
                $display("FAIL rr_order k=%0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                         k, gnt_id[k], gnt_cyc[k], k % NR, 3 * k);
            end
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_backpressure();
        int            w;
        bit            ok;
        exp_t          e;
        logic [IW-1:0] hid;
        logic [BW:0]   hres;
        logic [15:0]   cnt0;
        rsp_ready = 1'b0;
        cnt0 = op_count;
        issue(1, 16'h7F00, 16'h0123, 1'b1, w);
        op1[3*BW +: BW] = 16'h0A0A;
        op2[3*BW +: BW] = 16'h0505;
        add_sub[3]      = 1'b0;
        req_valid[3]    = 1'b1;
        tick();
        hid  = rsp_id;
        hres = rsp_result;
        checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_rsp_valid got=%b want=1", rsp_valid);
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_result !== e.res) begin
                errors++;
                $display("FAIL bp_rsp got id=%0d res=%h want id=%0d res=%h", rsp_id, rsp_result, e.id, e.res);
            end
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_result !== hres || req_ready !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b id=%0d res=%h rdy=%b want v=1 id=%0d res=%h rdy=0000",
                         c, rsp_valid, rsp_id, rsp_result, req_ready, hid, hres);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks += 2;
        if (rsp_valid !== 1'b0)         begin errors++; $display("FAIL bp_complete rsp_valid got=%b want=0", rsp_valid); end
        if (op_count !== cnt0 + 16'd1)  begin errors++; $display("FAIL bp_op_count got=%h want=%h", op_count, cnt0 + 16'd1); end
        issue(3, 16'h0A0A, 16'h0505, 1'b0, w);
        wait_rsp(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_next_rsp no response within 16 cycles");
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_result !== e.res) begin
                errors++;
                $display("FAIL bp_next got id=%0d res=%h want id=%0d res=%h", rsp_id, rsp_result, e.id, e.res);
            end
        end
        tick();
    endtask

    // Reset while an operation is in EXEC (in_resp=0) or in RESP (in_resp=1).
    task automatic test_reset_mid(input bit in_resp);
        int   w;
        bit   ok;
        bit   seen;
        exp_t e;
        rsp_ready = 1'b1;
        issue(1, 16'h1111, 16'h2222, 1'b0, w);  // leaves rr_ptr at 2
        wait_rsp(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL mid_pre_rsp in_resp=%0d no response", in_resp);
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_result !== e.res) begin
                errors++;
                $display("FAIL mid_pre in_resp=%0d got id=%0d res=%h want id=%0d res=%h",
                         in_resp, rsp_id, rsp_result, e.id, e.res);
            end
        end
        tick();
        rsp_ready = 1'b0;
        issue(in_resp ? 3 : 2, 16'h4000, 16'h0100, 1'b1, w);
        if (in_resp) tick();
        checks++;
        if (rsp_valid !== in_resp) begin
            errors++;
            $display("FAIL mid_state in_resp=%0d rsp_valid got=%b want=%b", in_resp, rsp_valid, in_resp);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy in_resp=%0d got=%b want=0", in_resp, busy); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid in_resp=%0d got=%b want=0", in_resp, rsp_valid); end
        if (rsp_id !== 2'd0)    begin errors++; $display("FAIL mid_rsp_id in_resp=%0d got=%0d want=0", in_resp, rsp_id); end
        if (rsp_result !== '0)  begin errors++; $display("FAIL mid_rsp_result in_resp=%0d got=%h want=0", in_resp, rsp_result); end
        if (op_count !== 16'd0) begin errors++; $display("FAIL mid_op_count in_resp=%0d got=%h want=0", in_resp, op_count); end
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_ghost_rsp in_resp=%0d got rsp_valid=1 want 0", in_resp); end
        op1[3*BW +: BW] = 16'h0001;
        op2[3*BW +: BW] = 16'h0002;
        req_valid[3]    = 1'b1;
        req_valid[1]    = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_rr_ptr in_resp=%0d got=%b want=0010", in_resp, req_ready);
        end
        req_valid[3] = 1'b0;
        issue(1, 16'h0042, 16'h0024, 1'b1, w);
        wait_rsp(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL mid_post_rsp in_resp=%0d no response", in_resp);
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_result !== e.res) begin
                errors++;
                $display("FAIL mid_post in_resp=%0d got id=%0d res=%h want id=%0d res=%h",
                         in_resp, rsp_id, rsp_result, e.id, e.res);
            end
        end
        tick();
    endtask

    task automatic test_op_count_wrap();
        int          w;
        bit          ok;
        exp_t        e;
        logic [15:0] want[2] = '{16'hFFFF, 16'h0000};
        rsp_ready = 1'b1;
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        for (int v = 0; v < 2; v++) begin
            issue(v, 16'h0100 * 16'(v + 1), 16'h0080, 1'b0, w);
            wait_rsp(ok);
            checks++;
            if (!ok || exp_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_rsp v=%0d no response", v);
            end else begin
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_result !== e.res) begin
                    errors++;
                    $display("FAIL wrap_data v=%0d got id=%0d res=%h want id=%0d res=%h",
                             v, rsp_id, rsp_result, e.id, e.res);
                end
            end
            tick();
            checks++;
            if (op_count !== want[v]) begin
                errors++;
                $display("FAIL wrap_count v=%0d got=%h want=%h", v, op_count, want[v]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_subtract();
        test_round_robin();
        test_backpressure();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_op_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q8_8_addsub_arbiter.md
Name: q8_8_addsub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one instance of the team's Q8_8_AddSub combinational add/sub unit between NUM_REQ requesters. Each requester uses a valid/ready handshake.
- Accepted operations are registered, evaluated on the shared unit, and returned on a single response channel tagged with the requester index.
- Sits between the fixed-point ALU clients (filter taps, accumulators) and the shared datapath.

Parameters:
- BUS_WIDTH, 16, operand width (Q8.8).
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of the requester index; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept strobe.
- req_operand1  in  NUM_REQ*BUS_WIDTH  packed operand1; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_operand2  in  NUM_REQ*BUS_WIDTH  packed operand2, same packing.
- req_add_sub  in  NUM_REQ  per-requester select: 0 = add, 1 = subtract.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_WIDTH  index of the requester that owns the response.
- rsp_result  out  BUS_WIDTH+1  result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-response counter; wraps.

Behaviour:
- Reset (rst_n low at a clk edge, in any state):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, op_count=0.
  - Latched operands cleared.
  - Reset mid-operation discards the in-flight operation with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index searching upward from rr_ptr, wrapping at NUM_REQ.
  - Drive req_ready[grant]=1 combinationally in that cycle only; all other req_ready bits are 0. req_ready is never high outside IDLE.
  - At the edge: latch operand1, operand2, add_sub and grant; go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - Latched operands drive the shared Q8_8_AddSub.
  - At the edge: register its output into rsp_result and grant into rsp_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_result stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, op_count+=1 (0xFFFF wraps to 0x0000), rr_ptr=(grant+1) mod NUM_REQ; go to IDLE.
- Latency and throughput:
  - Accept at edge T gives rsp_valid high after edge T+1.
  - With rsp_ready held high, back-to-back throughput is one operation per 3 cycles.
- Arithmetic (unsigned, BUS_WIDTH+1-bit result, bit-exact with Q8_8_AddSub):
  - add: operand1+operand2, with the carry in the MSB.
  - sub: if operand1>operand2 then operand1-operand2, else operand2-operand1 (magnitude only; MSB=0).
  - Equal operands give 0.
- Fairness:
  - rr_ptr advances only on response completion.
  - A continuously valid requester is served at least once every NUM_REQ operations.
- Requester rules:
  - Requesters must hold valid and operands stable until req_ready is seen.
  - Deasserting req_valid before grant is legal and causes no state change.
- Simultaneous events:
  - A requester that re-raises valid while its own response is pending waits for IDLE.
  - rsp_ready high before rsp_valid has no effect.

Test Plan:
- Reset, then single add: requester 0 sends 0x0180 + 0x0040 -> req_ready[0] for one cycle, rsp_valid 2 cycles later, rsp_result=0x001C0, rsp_id=0, op_count=1.
- Subtract with swap: requester 2 sends op1=0x0100, op2=0x0300, sub -> 0x00200. Then op1=op2=0x1234 -> 0x00000. Carry: 0xFFFF+0x0001 add -> 0x10000.
- All four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,…; operations spaced 3 cycles apart; op_count=8 after 24 cycles.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable; no req_ready asserted; completes on the first rsp_ready cycle.
- Reset mid-EXEC and mid-RESP: rst_n low for one cycle -> all outputs 0, state IDLE, no response emitted; the next request is served from rr_ptr=0.
- op_count preloaded near wrap via 65536 completions (or force) -> 0xFFFF then 0x0000.
